// File: rtl/strb_chunk_pkg.sv
// strb_chunk_pkg: state type and alignment/coverage size rule for the chunk splitter
package strb_chunk_pkg;
  typedef enum logic {IDLE, EMIT} state_e;
  function automatic logic [2:0] chunk_log2(input logic [63:0] rem, input int p, input int max_log);
    logic [2:0] k;
    logic [63:0] m;
    k = '0;
    for (int j = 1; j <= 6; j++) begin
      m = ~({64{1'b1}} << (1 << j));
      if (j <= max_log && (p & ((1 << j) - 1)) == 0 && ((rem >> p) & m) == m) k = 3'(j);
    end
    return k;
  endfunction
endpackage

// File: rtl/strb_chunk_pick.sv
// strb_chunk_pick: largest aligned, fully-strobed power-of-two chunk at the lowest set lane
module strb_chunk_pick
  import strb_chunk_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  parameter int MAX_CHUNK = DATA_BYTES,
  localparam int OFF_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
) (
  input  logic [DATA_BYTES-1:0] rem,
  output logic [DATA_BYTES-1:0] mask,
  output logic [OFF_W-1:0]      offset,
  output logic [2:0]            size
);
  int p;
  logic [2:0] k;
  logic [63:0] m;
  always_comb begin
    p = 0;
    for (int i = DATA_BYTES - 1; i >= 0; i--) if (rem[i]) p = i;
    k = chunk_log2(64'(rem), p, $clog2(MAX_CHUNK));
    m = ~({64{1'b1}} << (1 << k)) << p;
    mask = |rem ? m[DATA_BYTES-1:0] : '0;
    offset = p[OFF_W-1:0];
    size = k;
  end
endmodule

// File: rtl/strb_chunk_splitter.sv
// strb_chunk_splitter: splits an AXI write strobe into aligned power-of-two byte chunks
module strb_chunk_splitter
  import strb_chunk_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  parameter int MAX_CHUNK = DATA_BYTES,
  parameter int TAG_W = 4,
  localparam int OFF_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_BYTES-1:0] s_strb,
  input  logic [TAG_W-1:0]      s_tag,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_BYTES-1:0] m_mask,
  output logic [OFF_W-1:0]      m_offset,
  output logic [2:0]            m_size,
  output logic                  m_last,
  output logic                  m_empty,
  output logic [TAG_W-1:0]      m_tag,
  output logic                  busy
);
  state_e state, state_n;
  logic [DATA_BYTES-1:0] rem, rem_n;
  logic empty, s_xfer, m_xfer;
  strb_chunk_pick #(.DATA_BYTES(DATA_BYTES), .MAX_CHUNK(MAX_CHUNK)) u_pick (
    .rem(rem), .mask(m_mask), .offset(m_offset), .size(m_size)
  );
  always_comb begin
    m_valid = state == EMIT;
    busy = m_valid;
    rem_n = rem & ~m_mask;
    m_last = m_valid && rem_n == '0;
    m_empty = m_valid && empty;
    s_ready = !m_valid || (m_last && m_ready);
    s_xfer = s_valid && s_ready;
    m_xfer = m_valid && m_ready;
    state_n = s_xfer ? EMIT : (m_xfer && m_last) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem <= '0;
      m_tag <= '0;
      empty <= 1'b0;
    end else begin
      state <= state_n;
      rem <= s_xfer ? s_strb : m_xfer ? rem_n : rem;
      m_tag <= s_xfer ? s_tag : m_tag;
      empty <= s_xfer ? ~|s_strb : empty;
    end
  end
endmodule

// File: tb/tb_strb_chunk_splitter.sv
// tb_strb_chunk_splitter: directed table-driven checks of strobe chunk splitting
module tb_strb_chunk_splitter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic s_valid = 1'b0, m_ready = 1'b0;
  logic [7:0] s_strb = '0;
  logic [3:0] s_tag = '0;
  logic s_ready, m_valid, m_last, m_empty, busy;
  logic [7:0] m_mask;
  logic [2:0] m_offset, m_size;
  logic [3:0] m_tag;
  logic s_ready2, m_valid2, m_last2, m_empty2, busy2;
  logic [7:0] m_mask2;
  logic [2:0] m_offset2, m_size2;
  logic [3:0] m_tag2;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  strb_chunk_splitter #(.DATA_BYTES(8), .MAX_CHUNK(8), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_strb(s_strb),
    .s_tag(s_tag), .m_valid(m_valid), .m_ready(m_ready), .m_mask(m_mask),
    .m_offset(m_offset), .m_size(m_size), .m_last(m_last), .m_empty(m_empty),
    .m_tag(m_tag), .busy(busy)
  );
  strb_chunk_splitter #(.DATA_BYTES(8), .MAX_CHUNK(2), .TAG_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready2), .s_strb(s_strb),
    .s_tag(s_tag), .m_valid(m_valid2), .m_ready(m_ready), .m_mask(m_mask2),
    .m_offset(m_offset2), .m_size(m_size2), .m_last(m_last2), .m_empty(m_empty2),
    .m_tag(m_tag2), .busy(busy2)
  );

  typedef struct packed {
    logic       first;
    logic [7:0] strb;
    logic [3:0] tag;
    logic [7:0] mask;
    logic [2:0] off;
    logic [2:0] sz;
    logic       last;
    logic       empty;
  } vec_t;
  vec_t vec[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk2(input string name, input logic [7:0] mask, input logic [2:0] off, input logic last);
    chk({name, " valid"}, {31'd0, m_valid2}, 1);
    chk({name, " mask"}, {24'd0, m_mask2}, {24'd0, mask});
    chk({name, " off"}, {29'd0, m_offset2}, {29'd0, off});
    chk({name, " size"}, {29'd0, m_size2}, {29'd0, (mask == 8'h00) ? 3'd0 : (mask == 8'h01 || mask == 8'h04 || mask == 8'h10 || mask == 8'h40) ? 3'd0 : 3'd1});
    chk({name, " last"}, {31'd0, m_last2}, {31'd0, last});
  endtask

  initial begin
    vec[0]  = '{1'b1, 8'hFF, 4'h1, 8'hFF, 3'd0, 3'd3, 1'b1, 1'b0};
    vec[1]  = '{1'b1, 8'h0F, 4'h5, 8'h0F, 3'd0, 3'd2, 1'b1, 1'b0};
    vec[2]  = '{1'b1, 8'hFE, 4'h2, 8'h02, 3'd1, 3'd0, 1'b0, 1'b0};
    vec[3]  = '{1'b0, 8'hFE, 4'h2, 8'h0C, 3'd2, 3'd1, 1'b0, 1'b0};
    vec[4]  = '{1'b0, 8'hFE, 4'h2, 8'hF0, 3'd4, 3'd2, 1'b1, 1'b0};
    vec[5]  = '{1'b1, 8'h00, 4'h3, 8'h00, 3'd0, 3'd0, 1'b1, 1'b1};
    vec[6]  = '{1'b1, 8'hA5, 4'h4, 8'h01, 3'd0, 3'd0, 1'b0, 1'b0};
    vec[7]  = '{1'b0, 8'hA5, 4'h4, 8'h04, 3'd2, 3'd0, 1'b0, 1'b0};
    vec[8]  = '{1'b0, 8'hA5, 4'h4, 8'h20, 3'd5, 3'd0, 1'b0, 1'b0};
    vec[9]  = '{1'b0, 8'hA5, 4'h4, 8'h80, 3'd7, 3'd0, 1'b1, 1'b0};
    vec[10] = '{1'b1, 8'hF3, 4'h6, 8'h03, 3'd0, 3'd1, 1'b0, 1'b0};
    vec[11] = '{1'b0, 8'hF3, 4'h6, 8'hF0, 3'd4, 3'd2, 1'b1, 1'b0};

    #12;
    chk("rst m_valid", {31'd0, m_valid}, 0);
    chk("rst s_ready", {31'd0, s_ready}, 1);
    chk("rst busy", {31'd0, busy}, 0);
    chk("rst m_mask", {24'd0, m_mask}, 0);
    chk("rst m_offset", {29'd0, m_offset}, 0);
    chk("rst m_size", {29'd0, m_size}, 0);
    chk("rst m_last", {31'd0, m_last}, 0);
    chk("rst m_empty", {31'd0, m_empty}, 0);
    chk("rst m_tag", {28'd0, m_tag}, 0);
    rst_n = 1'b1;
    step();

    // back-to-back stream with m_ready held high; next word loads on the last chunk
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_strb = vec[0].strb;
    s_tag = vec[0].tag;
    step();
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("v%0d valid", i), {31'd0, m_valid}, 1);
      chk($sformatf("v%0d mask", i), {24'd0, m_mask}, {24'd0, vec[i].mask});
      chk($sformatf("v%0d off", i), {29'd0, m_offset}, {29'd0, vec[i].off});
      chk($sformatf("v%0d size", i), {29'd0, m_size}, {29'd0, vec[i].sz});
      chk($sformatf("v%0d last", i), {31'd0, m_last}, {31'd0, vec[i].last});
      chk($sformatf("v%0d empty", i), {31'd0, m_empty}, {31'd0, vec[i].empty});
      chk($sformatf("v%0d tag", i), {28'd0, m_tag}, {28'd0, vec[i].tag});
      chk($sformatf("v%0d s_ready", i), {31'd0, s_ready}, {31'd0, vec[i].last});
      if (i < 11 && vec[i + 1].first) begin
        s_valid = 1'b1;
        s_strb = vec[i + 1].strb;
        s_tag = vec[i + 1].tag;
      end else begin
        s_valid = 1'b0;
        s_strb = 8'h5A;
        s_tag = 4'hE;
      end
      step();
    end
    chk("stream idle valid", {31'd0, m_valid}, 0);
    chk("stream idle busy", {31'd0, busy}, 0);

    // stall on first chunk; inputs offered during the stall must be ignored
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_strb = 8'h3C;
    s_tag = 4'h9;
    step();
    s_strb = 8'hFF;
    s_tag = 4'h1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall%0d mask", c), {24'd0, m_mask}, 32'h0C);
      chk($sformatf("stall%0d off", c), {29'd0, m_offset}, 2);
      chk($sformatf("stall%0d size", c), {29'd0, m_size}, 1);
      chk($sformatf("stall%0d last", c), {31'd0, m_last}, 0);
      chk($sformatf("stall%0d tag", c), {28'd0, m_tag}, 9);
      chk($sformatf("stall%0d s_ready", c), {31'd0, s_ready}, 0);
      chk($sformatf("stall%0d busy", c), {31'd0, busy}, 1);
      step();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    chk("stall accept s_ready", {31'd0, s_ready}, 0);
    step();
    chk("stall tail mask", {24'd0, m_mask}, 32'h30);
    chk("stall tail off", {29'd0, m_offset}, 4);
    chk("stall tail size", {29'd0, m_size}, 1);
    chk("stall tail last", {31'd0, m_last}, 1);
    chk("stall tail tag", {28'd0, m_tag}, 9);
    chk("stall tail s_ready", {31'd0, s_ready}, 1);
    step();
    chk("stall done valid", {31'd0, m_valid}, 0);

    // MAX_CHUNK=2 instance from a clean reset
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    chk("mc2 idle valid", {31'd0, m_valid2}, 0);
    s_valid = 1'b1;
    s_strb = 8'hFF;
    s_tag = 4'h7;
    step();
    s_valid = 1'b0;
    chk2("mc2 c0", 8'h03, 3'd0, 1'b0);
    chk("mc2 tag", {28'd0, m_tag2}, 7);
    step();
    chk2("mc2 c1", 8'h0C, 3'd2, 1'b0);
    step();
    chk2("mc2 c2", 8'h30, 3'd4, 1'b0);
    step();
    chk2("mc2 c3", 8'hC0, 3'd6, 1'b1);
    step();
    chk("mc2 idle2 valid", {31'd0, m_valid2}, 0);
    s_valid = 1'b1;
    s_strb = 8'h55;
    s_tag = 4'h3;
    step();
    s_valid = 1'b0;
    chk2("mc2 55 c0", 8'h01, 3'd0, 1'b0);
    step();
    chk2("mc2 55 c1", 8'h04, 3'd2, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mc2 rst valid", {31'd0, m_valid2}, 0);
    chk("mc2 rst busy", {31'd0, busy2}, 0);
    chk("mc2 rst mask", {24'd0, m_mask2}, 0);
    #3;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("mc2 post%0d valid", c), {31'd0, m_valid2}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
